// File: rtl/merge_pkg.sv
// Shared types and constants for the synchronous N-input two-phase merge.
package merge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } merge_state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;
  localparam int CNT_W     = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_merge_arb_n_if.sv
// Drive/free bundle between N producers, the merge and its single consumer.
interface sync_merge_arb_n_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32
);
  logic [N-1:0]            i_drive;
  logic [N*DATA_WIDTH-1:0] i_data;
  logic [N-1:0]            o_free;
  logic                    o_driveNext;
  logic [DATA_WIDTH-1:0]   o_data;
  logic                    i_freeNext;
  logic [N-1:0]            o_grant;
  logic                    o_busy;
  logic                    o_err;

  modport master (
    output i_drive, i_data, i_freeNext,
    input  o_free, o_driveNext, o_data, o_grant, o_busy, o_err
  );

  modport slave (
    input  i_drive, i_data, i_freeNext,
    output o_free, o_driveNext, o_data, o_grant, o_busy, o_err
  );
endinterface

// File: rtl/rr_arbiter_n.sv
// Combinational winner picker: round-robin from ptr, or lowest index first.
module rr_arbiter_n
  import merge_pkg::*;
#(
  parameter int  N        = 4,
  parameter int  ARB_MODE = ARB_RR,
  localparam int IW       = idx_width(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int   k;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      if (ARB_MODE == ARB_FIXED) k = i;
      else                       k = (int'(ptr) + i) % N;
      if (!found && pending[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

  assign valid = |pending;

endmodule

// File: rtl/sync_merge_arb_n.sv
// N-input two-phase merge: arbitrates pending drive toggles and forwards one
// transaction at a time, with its payload, to a single downstream channel.
module sync_merge_arb_n
  import merge_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int N           = 4,
  parameter int ARB_MODE    = ARB_RR,
  parameter int ACK_DELAY   = 4,
  parameter int SYNC_STAGES = 0
) (
  input logic               clk,
  input logic               rst,
  sync_merge_arb_n_if.slave bus
);

  // state | meaning
  // IDLE  | nothing in flight; grant the arbiter winner as soon as one is pending
  // SEND  | o_driveNext toggled, waiting for the matching i_freeNext toggle
  // HOLD  | acknowledged, counting the remaining ACK_DELAY cycles before o_free[g]

  localparam int IW = idx_width(N);
  // The acknowledge edge is the first of the ACK_DELAY cycles, so HOLD runs one short.
  localparam logic [CNT_W-1:0] CNT_LOAD = (ACK_DELAY > 0) ? CNT_W'(ACK_DELAY - 1) : '0;

  merge_state_e          state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [N-1:0]          free_q, free_n;
  logic [N-1:0]          grant_q, grant_n;
  logic [N-1:0]          arb_grant, pending, drive_s;
  logic                  dn_q, dn_n;
  logic                  err_q, err_n;
  logic                  free_s, free_d;
  logic                  arb_valid, done;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic [IW-1:0]         gidx, gidx_n, ptr, ptr_n, arb_idx;
  logic [DATA_WIDTH-1:0] data_arr [N];
  logic [N:0]            raw_in, sync_in;

  assign raw_in = {bus.i_freeNext, bus.i_drive};

  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync_in = raw_in;
  end else begin : g_sync
    logic [N:0] stage [SYNC_STAGES];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
      end else begin
        stage[0] <= raw_in;
        for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      end
    end
    assign sync_in = stage[SYNC_STAGES-1];
  end

  assign drive_s = sync_in[N-1:0];
  assign free_s  = sync_in[N];
  assign pending = drive_s ^ free_q;

  for (genvar g = 0; g < N; g++) begin : g_data
    assign data_arr[g] = bus.i_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter_n #(
    .N        (N),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .pending (pending),
    .ptr     (ptr),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .valid   (arb_valid)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    free_n  = free_q;
    dn_n    = dn_q;
    data_n  = data_q;
    grant_n = grant_q;
    gidx_n  = gidx;
    ptr_n   = ptr;
    err_n   = err_q;
    done    = 1'b0;
    // An acknowledge toggle outside SEND has nothing to pair with: flag it, otherwise ignore it.
    if ((state != SEND) && (free_s != free_d)) err_n = 1'b1;
    unique case (state)
      IDLE: begin
        if (arb_valid) begin
          data_n  = data_arr[arb_idx];
          grant_n = arb_grant;
          gidx_n  = arb_idx;
          dn_n    = ~dn_q;
          state_n = SEND;
        end
      end
      SEND: begin
        if (free_s == dn_q) begin
          if (ACK_DELAY == 0) begin
            done = 1'b1;
          end else begin
            cnt_n   = CNT_LOAD;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else           done  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (done) begin
      free_n[gidx] = ~free_q[gidx];
      grant_n      = '0;
      ptr_n        = (gidx == IW'(N-1)) ? '0 : gidx + 1'b1;
      state_n      = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      free_q  <= '0;
      dn_q    <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      gidx    <= '0;
      ptr     <= '0;
      err_q   <= 1'b0;
      free_d  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      free_q  <= free_n;
      dn_q    <= dn_n;
      data_q  <= data_n;
      grant_q <= grant_n;
      gidx    <= gidx_n;
      ptr     <= ptr_n;
      err_q   <= err_n;
      free_d  <= free_s;
    end
  end

  assign bus.o_free      = free_q;
  assign bus.o_driveNext = dn_q;
  assign bus.o_data      = data_q;
  assign bus.o_grant     = grant_q;
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_sync_merge_arb_n.sv
// Bench for sync_merge_arb_n in three builds: RR/D=4/S=0, fixed/D=4/S=0, RR/D=0/S=2.
module tb_sync_merge_arb_n;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic [2:0]   rst;
  logic [3:0]   drv     [3];
  logic [127:0] dat     [3];
  logic         fn      [3];
  wire  [3:0]   fr      [3];
  wire          dn      [3];
  wire  [31:0]  od      [3];
  wire  [3:0]   gr      [3];
  wire          bs      [3];
  wire          er      [3];
  logic         dn_seen [3];
  logic [3:0]   fr_exp  [3];
  exp_t         exp_q[$];
  int           n_chk  = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  for (genvar u = 0; u < 3; u++) begin : g_u
    sync_merge_arb_n_if #(.N(4), .DATA_WIDTH(32)) bus ();
    assign bus.i_drive    = drv[u];
    assign bus.i_data     = dat[u];
    assign bus.i_freeNext = fn[u];
    assign fr[u] = bus.o_free;
    assign dn[u] = bus.o_driveNext;
    assign od[u] = bus.o_data;
    assign gr[u] = bus.o_grant;
    assign bs[u] = bus.o_busy;
    assign er[u] = bus.o_err;
    sync_merge_arb_n #(
      .DATA_WIDTH  (32),
      .N           (4),
      .ARB_MODE    ((u == 1) ? 1 : 0),
      .ACK_DELAY   ((u == 2) ? 0 : 4),
      .SYNC_STAGES ((u == 2) ? 2 : 0)
    ) dut (
      .clk (clk),
      .rst (rst[u]),
      .bus (bus)
    );
  end

  function automatic int dly(input int u);
    return (u == 2) ? 0 : 4;
  endfunction

  function automatic int syn(input int u);
    return (u == 2) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input int u, input int k, input logic [31:0] d);
    dat[u][k*32 +: 32] = d;
    drv[u][k] = ~drv[u][k];
  endtask

  task automatic sb_push(input int k, input logic [31:0] d);
    exp_t e;
    e.idx  = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Wait for the next o_driveNext toggle and score it against the queue.
  task automatic wait_grant(input int u, input int dlat, input bit ordered, output int idx);
    int   n;
    bit   hit;
    exp_t e;
    n = 0;
    while (dn[u] === dn_seen[u] && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("grant_timeout", 64'(dn[u] !== dn_seen[u]), 64'd1);
    if (dlat >= 0) chk("drive_lat", 64'(n), 64'(dlat));
    dn_seen[u] = dn[u];
    @(negedge clk);
    idx = 0;
    for (int k = 0; k < 4; k++) if (gr[u][k]) idx = k;
    chk("grant_onehot", 64'($onehot(gr[u])), 64'd1);
    chk("busy_send", 64'(bs[u]), 64'd1);
    hit    = 1'b0;
    e.idx  = 0;
    e.data = '0;
    if (ordered) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        hit = 1'b1;
        chk("grant_vec", 64'(gr[u]), 64'd1 << e.idx);
      end
    end else begin
      for (int j = 0; j < exp_q.size(); j++) begin
        if (!hit && exp_q[j].idx == idx) begin
          e = exp_q[j];
          exp_q.delete(j);
          hit = 1'b1;
        end
      end
      chk("sb_hit", 64'(hit), 64'd1);
    end
    if (hit) chk("grant_data", 64'(od[u]), 64'(e.data));
  endtask

  task automatic ack(input int u, input int idx);
    int n;
    @(posedge clk);
    #1;
    fn[u] = ~fn[u];
    n = 0;
    while (fr[u] === fr_exp[u] && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    fr_exp[u][idx] = ~fr_exp[u][idx];
    chk("ack_lat", 64'(n), 64'(dly(u) + 1 + syn(u)));
    chk("free_vec", 64'(fr[u]), 64'(fr_exp[u]));
    chk("grant_clear", 64'(gr[u]), 64'd0);
  endtask

  task automatic clear_mirror(input int u);
    drv[u]     = '0;
    fn[u]      = 1'b0;
    dn_seen[u] = 1'b0;
    fr_exp[u]  = '0;
  endtask

  task automatic zero_outs(input string tag, input int u);
    chk({tag, "_free"},  64'(fr[u]), 64'd0);
    chk({tag, "_dn"},    64'(dn[u]), 64'd0);
    chk({tag, "_data"},  64'(od[u]), 64'd0);
    chk({tag, "_grant"}, 64'(gr[u]), 64'd0);
    chk({tag, "_busy"},  64'(bs[u]), 64'd0);
    chk({tag, "_err"},   64'(er[u]), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          idx;
    int          reqs;
    int          grants;
    logic [3:0]  pend;
    logic [3:0]  m;
    logic [31:0] d;

    rst = 3'b111;
    for (int u = 0; u < 3; u++) begin
      clear_mirror(u);
      dat[u] = '0;
    end
    step(3);
    rst = 3'b000;
    step(1);
    for (int u = 0; u < 3; u++) zero_outs("reset", u);

    // Round-robin contention from pointer 0.
    for (int k = 0; k < 4; k++) req(0, k, 32'h1000_0000 | 32'(k));
    for (int k = 0; k < 4; k++) sb_push(k, 32'h1000_0000 | 32'(k));
    for (int i = 0; i < 4; i++) begin
      wait_grant(0, (i == 0) ? 1 : -1, 1'b1, idx);
      ack(0, idx);
    end

    // One transaction on channel 0 leaves the pointer at 1.
    req(0, 0, 32'h0000_00C0);
    sb_push(0, 32'h0000_00C0);
    wait_grant(0, 1, 1'b1, idx);
    ack(0, idx);

    for (int k = 0; k < 4; k++) req(0, k, 32'h2000_0000 | 32'(k));
    sb_push(1, 32'h2000_0001);
    sb_push(2, 32'h2000_0002);
    sb_push(3, 32'h2000_0003);
    sb_push(0, 32'h2000_0000);
    for (int i = 0; i < 4; i++) begin
      wait_grant(0, -1, 1'b1, idx);
      ack(0, idx);
    end

    // Single channel with latency checks.
    req(0, 2, 32'hA5A5_0002);
    sb_push(2, 32'hA5A5_0002);
    wait_grant(0, 1, 1'b1, idx);
    ack(0, idx);

    // Unsolicited acknowledge while idle.
    fn[0] = ~fn[0];
    step(1);
    chk("err_set", 64'(er[0]), 64'd1);
    chk("unsol_grant", 64'(gr[0]), 64'd0);
    chk("unsol_busy", 64'(bs[0]), 64'd0);
    chk("unsol_free", 64'(fr[0]), 64'(fr_exp[0]));
    chk("unsol_dn", 64'(dn[0]), 64'(dn_seen[0]));
    chk("unsol_data", 64'(od[0]), 64'hA5A5_0002);
    step(4);
    chk("err_sticky", 64'(er[0]), 64'd1);

    // Reset in the middle of SEND.
    rst[0] = 1'b1;
    clear_mirror(0);
    step(2);
    rst[0] = 1'b0;
    step(1);
    chk("err_cleared", 64'(er[0]), 64'd0);
    req(0, 1, 32'h0000_5A01);
    sb_push(1, 32'h0000_5A01);
    wait_grant(0, 1, 1'b1, idx);
    chk("send_dn", 64'(dn[0]), 64'd1);
    chk("send_grant", 64'(gr[0]), 64'b0010);
    rst[0] = 1'b1;
    #1;
    zero_outs("midrst", 0);
    clear_mirror(0);
    step(1);
    rst[0] = 1'b0;
    step(1);
    req(0, 1, 32'h0000_5A11);
    sb_push(1, 32'h0000_5A11);
    wait_grant(0, 1, 1'b1, idx);
    ack(0, idx);
    chk("post_rst_err", 64'(er[0]), 64'd0);

    // Fixed priority: 3 and 1 pending, 0 arrives while 1 is in flight.
    req(1, 3, 32'hF000_0003);
    req(1, 1, 32'hF000_0001);
    sb_push(1, 32'hF000_0001);
    sb_push(0, 32'hF000_0000);
    sb_push(3, 32'hF000_0003);
    wait_grant(1, 1, 1'b1, idx);
    req(1, 0, 32'hF000_0000);
    ack(1, idx);
    wait_grant(1, -1, 1'b1, idx);
    ack(1, idx);
    wait_grant(1, -1, 1'b1, idx);
    ack(1, idx);
    chk("fixed_err", 64'(er[1]), 64'd0);

    // Two synchroniser stages, no acknowledge delay.
    req(2, 3, 32'hC3C3_0003);
    sb_push(3, 32'hC3C3_0003);
    wait_grant(2, 3, 1'b1, idx);
    ack(2, idx);

    pend   = '0;
    reqs   = 0;
    grants = 0;
    for (int r = 0; r < 40; r++) begin
      m = 4'($urandom_range(0, 15)) & ~pend;
      for (int k = 0; k < 4; k++) begin
        if (m[k]) begin
          d = $urandom;
          req(2, k, d);
          sb_push(k, d);
          reqs++;
        end
      end
      pend = pend | m;
      if (pend != '0) begin
        wait_grant(2, -1, 1'b0, idx);
        ack(2, idx);
        pend[idx] = 1'b0;
        grants++;
      end
    end
    while (pend != '0 && grants < 200) begin
      wait_grant(2, -1, 1'b0, idx);
      ack(2, idx);
      pend[idx] = 1'b0;
      grants++;
    end
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("txn_count", 64'(grants), 64'(reqs));
    chk("sync_err", 64'(er[2]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
